// File: rtl/jlsemi_util_clkdiv_prog.sv
`timescale 1ns/1ps
// Runtime-programmable integer clock divider (50% duty, odd or even ratio) with a
// phase-shifted companion output; ratio/phase changes take effect at a period boundary.
module jlsemi_util_clkdiv_prog #(
    parameter int DIV_W     = 4,
    parameter int PHASE_W   = 2,
    parameter int DIV_RST   = 3,
    parameter int PHASE_RST = 0
) (
    input  logic               clk_in,
    input  logic               rstn_in,
    input  logic               dft_stuck_at_mode,
    input  logic               dft_tpi_clk,
    input  logic               dft_clkdiv_rstn_ctrl,
    input  logic               dft_clkdiv_scan_rstn,
    input  logic               dft_scan_en,
    input  logic [DIV_W-1:0]   rf_div_ratio,
    input  logic [PHASE_W-1:0] rf_div_phase,
    input  logic               rf_div_update,
    output logic               clk_out,
    output logic               clk_out_phase,
    output logic               div_busy,
    output logic               div_update_ack,
    output logic               div_cfg_err
);

    localparam logic [DIV_W-1:0]   LP_DIV_RST = DIV_W'(DIV_RST);
    localparam logic [PHASE_W-1:0] LP_PH_RST  = PHASE_W'(PHASE_RST);
    localparam logic [DIV_W-1:0]   LP_ONE     = DIV_W'(1);

    logic               w_rstn_async;
    logic               w_rstn;
    logic [1:0]         r_rst_sync;

    logic [DIV_W-1:0]   r_cnt;
    logic [DIV_W-1:0]   r_n_act;
    logic [PHASE_W-1:0] r_p_act;
    logic [DIV_W-1:0]   r_n_shd;
    logic [PHASE_W-1:0] r_p_shd;
    logic               r_busy;
    logic               r_ack;
    logic               r_err;
    logic               r_odd;
    logic               r_qp;
    logic               r_qn;
    logic               r_qpp;
    logic               r_qpn;

    logic               w_req;
    logic               w_bad;
    logic               w_req_ok;
    logic               w_wrap;
    logic               w_apply;
    logic [DIV_W-1:0]   w_n_nxt;
    logic [PHASE_W-1:0] w_p_nxt;
    logic [DIV_W-1:0]   w_p_ext;
    logic [DIV_W-1:0]   w_cnt_nxt;
    logic [DIV_W-1:0]   w_pcnt_nxt;
    logic [DIV_W-1:0]   w_half_nxt;
    logic               w_clk_div;
    logic               w_clk_ph;

    // Reset asserts asynchronously, releases two clk_in edges later
    assign w_rstn_async = dft_clkdiv_rstn_ctrl ? dft_clkdiv_scan_rstn : rstn_in;

    always_ff @(posedge clk_in or negedge w_rstn_async) begin
        if (!w_rstn_async) r_rst_sync <= 2'b00;
        else               r_rst_sync <= {r_rst_sync[0], 1'b1};
    end

    assign w_rstn = r_rst_sync[1];

    assign w_req    = rf_div_update & ~dft_scan_en;
    assign w_bad    = (rf_div_ratio < DIV_W'(2)) | (DIV_W'(rf_div_phase) >= rf_div_ratio);
    assign w_req_ok = w_req & ~w_bad;
    assign w_wrap   = (r_cnt == r_n_act - LP_ONE);
    assign w_apply  = w_wrap & r_busy;

    // Duty decisions use the next-cycle count and setting so each flop is
    // high exactly while its count sits below half the ratio
    assign w_n_nxt    = w_apply ? r_n_shd : r_n_act;
    assign w_p_nxt    = w_apply ? r_p_shd : r_p_act;
    assign w_p_ext    = DIV_W'(w_p_nxt);
    assign w_cnt_nxt  = w_wrap ? '0 : r_cnt + LP_ONE;
    assign w_half_nxt = w_n_nxt >> 1;
    assign w_pcnt_nxt = (w_cnt_nxt >= w_p_ext) ? (w_cnt_nxt - w_p_ext)
                                               : (w_cnt_nxt + w_n_nxt - w_p_ext);

    always_ff @(posedge clk_in or negedge w_rstn) begin
        if (!w_rstn) begin
            r_cnt   <= LP_DIV_RST - LP_ONE;
            r_n_act <= LP_DIV_RST;
            r_p_act <= LP_PH_RST;
            r_n_shd <= LP_DIV_RST;
            r_p_shd <= LP_PH_RST;
            r_busy  <= 1'b0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_odd   <= LP_DIV_RST[0];
            r_qp    <= 1'b0;
            r_qpp   <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_n_act <= w_n_nxt;
            r_p_act <= w_p_nxt;
            r_odd   <= w_n_nxt[0];
            r_qp    <= (w_cnt_nxt < w_half_nxt);
            r_qpp   <= (w_pcnt_nxt < w_half_nxt);
            r_ack   <= w_apply;
            r_err   <= w_req & w_bad;
            if (w_req_ok) begin
                r_n_shd <= rf_div_ratio;
                r_p_shd <= rf_div_phase;
            end
            // A request landing on the apply edge stays pending for the next boundary
            if (w_req_ok)     r_busy <= 1'b1;
            else if (w_apply) r_busy <= 1'b0;
        end
    end

    // Odd gating is folded into the negedge flop so a ratio change never
    // truncates a half-period extension already in flight
    always_ff @(negedge clk_in or negedge w_rstn) begin
        if (!w_rstn) begin
            r_qn  <= 1'b0;
            r_qpn <= 1'b0;
        end else begin
            r_qn  <= r_qp & r_odd;
            r_qpn <= r_qpp & r_odd;
        end
    end

    assign w_clk_div = r_qp | r_qn;
    assign w_clk_ph  = r_qpp | r_qpn;

    assign clk_out        = dft_stuck_at_mode ? dft_tpi_clk : w_clk_div;
    assign clk_out_phase  = dft_stuck_at_mode ? dft_tpi_clk : w_clk_ph;
    assign div_busy       = r_busy;
    assign div_update_ack = r_ack;
    assign div_cfg_err    = r_err;

endmodule

// File: tb/tb_jlsemi_util_clkdiv_prog.sv
`timescale 1ns/1ps
// Bench for jlsemi_util_clkdiv_prog: measures output waveforms in ns and compares
// them with period = 2N, high = N, phase lag = 2P for a 2 ns source clock.
module tb_jlsemi_util_clkdiv_prog;

    localparam int DIV_W   = 4;
    localparam int PHASE_W = 3;

    logic               clk_in = 1'b0;
    logic               rstn_in = 1'b1;
    logic               dft_stuck_at_mode = 1'b0;
    logic               dft_tpi_clk = 1'b0;
    logic               dft_clkdiv_rstn_ctrl = 1'b0;
    logic               dft_clkdiv_scan_rstn = 1'b1;
    logic               dft_scan_en = 1'b0;
    logic [DIV_W-1:0]   rf_div_ratio = '0;
    logic [PHASE_W-1:0] rf_div_phase = '0;
    logic               rf_div_update = 1'b0;
    logic               clk_out;
    logic               clk_out_phase;
    logic               div_busy;
    logic               div_update_ack;
    logic               div_cfg_err;

    jlsemi_util_clkdiv_prog #(
        .DIV_W(DIV_W), .PHASE_W(PHASE_W), .DIV_RST(3), .PHASE_RST(0)
    ) dut (
        .clk_in(clk_in), .rstn_in(rstn_in),
        .dft_stuck_at_mode(dft_stuck_at_mode), .dft_tpi_clk(dft_tpi_clk),
        .dft_clkdiv_rstn_ctrl(dft_clkdiv_rstn_ctrl), .dft_clkdiv_scan_rstn(dft_clkdiv_scan_rstn),
        .dft_scan_en(dft_scan_en), .rf_div_ratio(rf_div_ratio), .rf_div_phase(rf_div_phase),
        .rf_div_update(rf_div_update), .clk_out(clk_out), .clk_out_phase(clk_out_phase),
        .div_busy(div_busy), .div_update_ack(div_update_ack), .div_cfg_err(div_cfg_err)
    );

    always #1 clk_in = ~clk_in;

    int n_chk = 0;
    int n_fail = 0;

    // Waveform observer: edge timestamps, last pulse widths, minimum pulse widths
    realtime t_rise = -1.0, t_fall = -1.0, t_prise = -1.0, t_pfall = -1.0;
    int last_per = 0, last_hi = 0, n_rise = 0, n_ack = 0, n_err = 0, n_ack_bad = 0;
    int min_hi = 1000, min_lo = 1000, min_phi = 1000, min_plo = 1000;
    int seen_per [0:63];

    always @(posedge clk_out) begin
        if (t_rise >= 0.0) begin
            last_per = int'($realtime - t_rise);
            if (last_per < 64) seen_per[last_per]++;
        end
        if (t_fall >= 0.0 && int'($realtime - t_fall) < min_lo) min_lo = int'($realtime - t_fall);
        t_rise = $realtime;
        n_rise++;
    end

    always @(negedge clk_out) begin
        if (t_rise >= 0.0) begin
            last_hi = int'($realtime - t_rise);
            if (last_hi < min_hi) min_hi = last_hi;
        end
        t_fall = $realtime;
    end

    always @(posedge clk_out_phase) begin
        if (t_pfall >= 0.0 && int'($realtime - t_pfall) < min_plo) min_plo = int'($realtime - t_pfall);
        t_prise = $realtime;
    end

    always @(negedge clk_out_phase) begin
        if (t_prise >= 0.0 && int'($realtime - t_prise) < min_phi) min_phi = int'($realtime - t_prise);
        t_pfall = $realtime;
    end

    // The ack must coincide with the clk_out rise at the apply edge
    always @(negedge clk_in) begin
        if (div_update_ack === 1'b1) begin
            n_ack++;
            if (!(clk_out === 1'b1 && int'($realtime - t_rise) == 1)) n_ack_bad++;
        end
        if (div_cfg_err === 1'b1) n_err++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
        n_chk++;
        assert (obs >= lo && obs <= hi) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #0.5;
        end
    endtask

    task automatic req(input int n, input int p);
        rf_div_ratio  = DIV_W'(n);
        rf_div_phase  = PHASE_W'(p);
        rf_div_update = 1'b1;
        step(1);
        rf_div_update = 1'b0;
    endtask

    task automatic wait_ack(input int limit, output int lat);
        lat = -1;
        for (int c = 1; c <= limit; c++) begin
            step(1);
            if (div_update_ack === 1'b1) begin
                lat = c;
                break;
            end
        end
    endtask

    // Land just after a clk_out rise, i.e. at the start of a divided period
    task automatic align();
        int found;
        found = 0;
        for (int c = 0; c < 64; c++) begin
            step(1);
            if ($realtime - t_rise < 1.0) begin
                found = 1;
                break;
            end
        end
        chk("align", found, 1);
    endtask

    task automatic clear_stats();
        min_hi = 1000; min_lo = 1000; min_phi = 1000; min_plo = 1000;
        foreach (seen_per[i]) seen_per[i] = 0;
    endtask

    function automatic int lag_ns();
        real d;
        d = t_prise - t_rise;
        if (d < 0.0) d = d + real'(last_per);
        return int'(d);
    endfunction

    task automatic chk_wave(input string tag, input int n, input int p);
        chk({tag, "_per"}, last_per, 2 * n);
        chk({tag, "_hi"},  last_hi,  n);
        chk({tag, "_lag"}, lag_ns(), 2 * p);
    endtask

    initial begin
        int lat, a0, e0, r0, cur_n, n, p, w, bn, bp, bound;
        foreach (seen_per[i]) seen_per[i] = 0;

        #0.2 rstn_in = 1'b0;
        step(3);
        chk("rst_clk_out", clk_out, 0);
        chk("rst_clk_phase", clk_out_phase, 0);
        chk("rst_busy", div_busy, 0);
        chk("rst_ack", div_update_ack, 0);
        chk("rst_err", div_cfg_err, 0);

        rstn_in = 1'b1;
        step(20);
        chk_wave("dflt", 3, 0);

        req(3, 1);
        wait_ack(5, lat);
        chk_rng("p1_lat", lat, 1, 3);
        step(12);
        chk_wave("p1", 3, 1);

        // Mid-period ratio and phase change
        step(1);
        clear_stats();
        a0 = n_ack;
        req(4, 2);
        wait_ack(5, lat);
        chk_rng("n4_lat", lat, 1, 3);
        step(20);
        chk("n4_acks", n_ack - a0, 1);
        chk_wave("n4", 4, 2);
        chk_rng("n4_min_hi", min_hi, 2, 1000);
        chk_rng("n4_min_lo", min_lo, 2, 1000);
        chk_rng("n4_min_phi", min_phi, 2, 1000);
        chk_rng("n4_min_plo", min_plo, 2, 1000);

        // Rejected requests
        e0 = n_err;
        req(1, 0);
        chk("rej_n1_err", div_cfg_err, 1);
        chk("rej_n1_busy", div_busy, 0);
        req(4, 5);
        chk("rej_p5_err", div_cfg_err, 1);
        chk("rej_p5_busy", div_busy, 0);
        step(1);
        chk("rej_err_cnt", n_err - e0, 2);
        step(16);
        chk_wave("rej", 4, 2);

        // Back-to-back requests inside one period: only the latest applies
        align();
        clear_stats();
        a0 = n_ack;
        req(5, 0);
        req(7, 0);
        wait_ack(8, lat);
        chk_rng("b2b_lat", lat, 1, 4);
        step(40);
        chk("b2b_acks", n_ack - a0, 1);
        chk_wave("b2b", 7, 0);
        chk("b2b_no_n5", seen_per[10], 0);

        // Reset mid-period with an update pending
        align();
        req(9, 2);
        chk("rstm_busy_pre", div_busy, 1);
        chk("rstm_clk_pre", clk_out, 1);
        a0 = n_ack;
        #0.2 rstn_in = 1'b0;
        #0.1;
        chk("rstm_clk_out", clk_out, 0);
        chk("rstm_clk_phase", clk_out_phase, 0);
        chk("rstm_busy", div_busy, 0);
        step(5);
        rstn_in = 1'b1;
        step(30);
        chk("rstm_acks", n_ack - a0, 0);
        chk_wave("rstm", 3, 0);

        // Scan enable masks requests
        dft_scan_en = 1'b1;
        req(5, 0);
        chk("scan_en_busy", div_busy, 0);
        req(1, 0);
        chk("scan_en_err", div_cfg_err, 0);
        dft_scan_en = 1'b0;

        // Randomized settings against the arithmetic model
        cur_n = 3;
        for (int it = 0; it < 6; it++) begin
            n = int'($urandom_range(15, 2));
            p = int'($urandom_range((n - 1 < 7) ? n - 1 : 7, 0));
            w = int'($urandom_range(cur_n - 1, 0));
            step(w);
            if ($urandom_range(1, 0) == 1) begin
                if ($urandom_range(1, 0) == 1) begin
                    bn = int'($urandom_range(1, 0));
                    bp = 0;
                end else begin
                    bn = int'($urandom_range(7, 2));
                    bp = int'($urandom_range(7, bn));
                end
                req(bn, bp);
                chk("rnd_bad_err", div_cfg_err, 1);
                chk("rnd_bad_busy", div_busy, 0);
            end
            clear_stats();
            a0 = n_ack;
            req(n, p);
            wait_ack(cur_n + 1, lat);
            chk_rng("rnd_lat", lat, 1, cur_n);
            step(3 * n + 4);
            chk("rnd_acks", n_ack - a0, 1);
            chk_wave("rnd", n, p);
            bound = 2 * (((cur_n < n) ? cur_n : n) / 2);
            chk_rng("rnd_min_hi", min_hi, bound, 1000);
            chk_rng("rnd_min_lo", min_lo, bound, 1000);
            cur_n = n;
        end
        chk("ack_align", n_ack_bad, 0);

        // Stuck-at: both clocks follow the test clock
        dft_stuck_at_mode = 1'b1;
        dft_tpi_clk = 1'b0;
        #0.2;
        chk("stuck_lo_out", clk_out, 0);
        chk("stuck_lo_phase", clk_out_phase, 0);
        dft_tpi_clk = 1'b1;
        #0.2;
        chk("stuck_hi_out", clk_out, 1);
        chk("stuck_hi_phase", clk_out_phase, 1);
        dft_tpi_clk = 1'b0;
        #0.2;
        dft_stuck_at_mode = 1'b0;
        step(4 * cur_n + 4);
        chk("stuck_exit_per", last_per, 2 * cur_n);

        // Scan reset overrides rstn_in
        dft_clkdiv_rstn_ctrl = 1'b1;
        dft_clkdiv_scan_rstn = 1'b0;
        #0.2;
        chk("scanrst_clk_out", clk_out, 0);
        chk("scanrst_clk_phase", clk_out_phase, 0);
        r0 = n_rise;
        req(4, 0);
        chk("scanrst_busy", div_busy, 0);
        step(20);
        chk("scanrst_no_rise", n_rise - r0, 0);
        dft_clkdiv_scan_rstn = 1'b1;
        step(30);
        chk_wave("scanrst_rel", 3, 0);
        dft_clkdiv_rstn_ctrl = 1'b0;

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/jlsemi_util_clkdiv_prog.md
# jlsemi_util_clkdiv_prog

Runtime-programmable integer clock divider, the parametrised successor to the fixed odd divider. Divides `clk_in` by any ratio N in 2..2^DIV_W-1, odd or even, with 50% duty. Also produces a second output, phase-shifted by a programmable number of `clk_in` cycles. Ratio and phase change glitch-free at a period boundary through a request/ack handshake. Used wherever packet-control logic needs a derived clock plus a phase-offset sampling clock, with the same DFT controls as the existing dividers.

## Interface
Parameters:
- DIV_W, 4, width of ratio field; max ratio 2^DIV_W-1
- PHASE_W, 2, width of phase field
- DIV_RST, 3, active ratio after reset (must be 2..2^DIV_W-1)
- PHASE_RST, 0, active phase after reset (must be < DIV_RST)

Ports:
- clk_in  in  1  source clock
- rstn_in  in  1  reset; one clock, reset asynchronous active-low
- dft_stuck_at_mode  in  1  1: both clock outputs driven from dft_tpi_clk
- dft_tpi_clk  in  1  test clock
- dft_clkdiv_rstn_ctrl  in  1  1: internal reset taken from dft_clkdiv_scan_rstn
- dft_clkdiv_scan_rstn  in  1  scan reset, active-low
- dft_scan_en  in  1  1: rf_div_update ignored
- rf_div_ratio  in  DIV_W  requested ratio N
- rf_div_phase  in  PHASE_W  requested phase P, in clk_in cycles
- rf_div_update  in  1  single-cycle request; sampled on clk_in posedge
- clk_out  out  1  divided clock
- clk_out_phase  out  1  clk_out delayed by P clk_in cycles
- div_busy  out  1  accepted update pending
- div_update_ack  out  1  one-cycle pulse when the new setting takes effect
- div_cfg_err  out  1  one-cycle pulse when a request is rejected

## Operation
- Internal reset = dft_clkdiv_rstn_ctrl ? dft_clkdiv_scan_rstn : rstn_in. It is asynchronous: it asserts immediately and is released by a synchronizer, so release is synchronous to clk_in.
- Active registers: N_a and P_a. Shadow registers: N_s and P_s. Reset loads DIV_RST and PHASE_RST.
- Counter cnt runs 0..N_a-1 on clk_in posedge and wraps to 0. It resets to DIV_RST-1, so the first posedge after release wraps it to 0.
- Duty cycle:
  - q_p (posedge flop) = 1 while cnt < floor(N_a/2).
  - Even N: clk_out = q_p.
  - Odd N: q_n = q_p resampled on clk_in negedge; clk_out = q_p | q_n, giving exactly N/2 clk_in periods high.
- Phase: a second path uses pcnt = (cnt - P_a) mod N_a, with identical duty logic, to drive clk_out_phase. P_a = 0 gives clk_out_phase identical to clk_out.
- Update request: rf_div_update=1 with dft_scan_en=0.
  - Rejected if rf_div_ratio < 2 or rf_div_phase >= rf_div_ratio. Rejection gives div_cfg_err=1 for the next cycle and leaves shadow, busy and outputs unchanged.
  - Otherwise shadow <= request and div_busy <= 1.
  - A new request while busy overwrites the shadow. Only the latest request is applied, with a single ack.
- Apply: on the posedge where cnt == N_a-1 and div_busy=1:
  - N_a <= N_s, P_a <= P_s, cnt <= 0, div_busy <= 0, div_update_ack = 1 for that cycle.
  - A request landing on that same posedge is held in the shadow for the next boundary. It is not merged into the current apply.
- Stuck-at mode: clk_out = clk_out_phase = dft_tpi_clk through a clock mux cell. Counter logic keeps running.
- Reset values: clk_out=0, clk_out_phase=0, div_busy=0, div_update_ack=0, div_cfg_err=0, q_p=q_n=0.

## Timing
- Output registers are driven directly: no combinational path from rf_* to the clocks.
- clk_out first rises at the first clk_in posedge after reset release (clk-to-q). clk_out_phase first rises P_a posedges later.
- Request to ack: 1 to N_a clk_in cycles. The ack coincides with the first clk_out rising edge at the new ratio.
- Glitch-free: no high or low pulse on either clock output is shorter than floor(min(N_old, N_new)/2) clk_in periods.
- Reset mid-period: outputs go to 0 asynchronously. A pending update is discarded.

## Test plan
- Reset with defaults (N=3, P=0), clk_in period 2 ns: clk_out period 6 ns, high 3 ns; clk_out_phase identical to clk_out. Then set P=1: clk_out_phase lags by 2 ns.
- Update to N=4, P=2 mid-period: exactly one div_update_ack at the wrap; new period 8 ns, high 4 ns; phase lag 4 ns; no short pulses.
- Request N=1, then N=4 with P=5: each gives a div_cfg_err pulse; div_busy stays 0; outputs unchanged.
- Back-to-back requests N=5 then N=7 within one period: single ack; period becomes 14 ns with 7 ns high; N=5 never appears.
- Assert rstn_in mid-period with an update pending: outputs go to 0 immediately, no ack; after release, N=DIV_RST.
- dft_stuck_at_mode=1: both outputs follow dft_tpi_clk. Then dft_clkdiv_rstn_ctrl=1 with dft_clkdiv_scan_rstn=0: divider held in reset regardless of rstn_in.
